decade_counter_chain: RTL and testbench
=======================================

Name: decade_counter_chain

Overview:
- Parametrised multi-digit decade (radix TOP+1) up/down counter built from per-digit counters.
- Carry/borrow ripples one digit per clock, emulating dekatron carry propagation.
- Generalises the single-digit up-counter with width (DIGITS), radix (TOP), down-count, load, clear, ready handshake and overflow/underflow flags.
- Used for the emulator's IP, AP, loop and data counters.

Parameters:
DIGITS, 6, number of 4-bit digits in the chain (1..8)
TOP, 4'd9, highest digit value; a digit wraps TOP->0 going up and 0->TOP going down (1..15)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous active-high reset
Inc  in  1  increment request, single-cycle, accepted when Ready=1
Dec  in  1  decrement request, single-cycle, accepted when Ready=1
Clear  in  1  synchronous clear, highest priority, accepted any time
Load  in  1  synchronous load of LoadValue, accepted any time
LoadValue  in  4*DIGITS  packed digits, digit 0 in bits [3:0]
Count  out  4*DIGITS  packed digit values, registered
Ready  out  1  1 when no carry/borrow is pending
Zero  out  1  1 when all digits are 0 (combinational from Count)
Overflow  out  1  one-cycle pulse: carry left the top digit
Underflow  out  1  one-cycle pulse: borrow left the top digit

Behaviour:
- One clock, Clk. Reset is asynchronous and active-high on Rst.
- Reset values: Count=0, state IDLE, Ready=1, Overflow=0, Underflow=0, digit pointer=0.
- FSM states: IDLE, CARRY_UP, BORROW_DN. Ready = (state==IDLE).
- Priority per cycle: Clear > Load > Inc/Dec.
- Clear: Count<=0, state<=IDLE, flags<=0. Aborts any pending propagation.
- Load: Count<=LoadValue, state<=IDLE, flags<=0. Aborts propagation.
  - Any loaded digit >TOP is stored as TOP.
- Inc and Dec both high with Ready=1: no-op, Count unchanged.
- Inc or Dec with Ready=0: ignored, not queued.
- Inc accepted (IDLE):
  - If digit0<TOP: digit0+1, stay IDLE.
  - If digit0==TOP: digit0<=0, ptr<=1, go to CARRY_UP.
  - If DIGITS==1, the wrap instead pulses Overflow and stays IDLE.
- CARRY_UP, each cycle:
  - If digit[ptr]<TOP: digit[ptr]+1, go to IDLE.
  - Else digit[ptr]<=0. If ptr==DIGITS-1: Overflow<=1 for one cycle, go to IDLE. Otherwise ptr+1.
- Dec and BORROW_DN: mirror image. Step condition is digit>0 (digit-1); wrap condition is digit==0 (digit<=TOP); Underflow replaces Overflow.
- Latency: digit k updates k cycles after the accepting edge. Ready is low for exactly k cycles when the ripple stops at digit k.
  - Worst case DIGITS-1 cycles.
  - Intermediate values are visible on Count by design.
- Overflow/Underflow assert on the same edge the top digit wraps, and clear on the next edge.
- Arithmetic is per digit, 4-bit, never binary across digits. Digit values never exceed TOP.

Optional Feature:
- Macro: DECADE_FAST_CARRY_EN.
- Defined:
  - Carry/borrow resolves combinationally through all digits in the accepting cycle.
  - Count is final one cycle after accept. FSM stays in IDLE; Ready is constant 1.
  - Overflow/Underflow pulse on that same edge.
- Undefined: ripple behaviour as above.
- Clear/Load semantics identical in both builds.

Test Plan:
(All scenarios use DIGITS=3, TOP=9, ripple build unless stated.)
- Reset mid-ripple: load 099, Inc, assert Rst on the next cycle -> Count=000, Ready=1, flags 0 immediately, without a clock edge.
- Ripple up: load 099, Inc -> Count 090 (Ready=0), then 000 (Ready=0), then 100 (Ready=1). Inc pulsed during Ready=0 -> ignored, final value stays 100.
- Overflow: load 999, Inc -> 990, 900, 000 with a one-cycle Overflow pulse on the 000 edge; Zero=1 afterwards. Mirror case: 000 Dec -> 009, 099, 999 with an Underflow pulse.
- Priority: Inc+Dec together at 456 -> 456 unchanged. Clear+Load(777) together -> 000. Load(777) during ripple from 099 -> 777, Ready=1 next cycle.
- Clamp and non-decimal radix: TOP=5, load digits {7,3,5} -> Count {5,3,5}. Inc on digit0=5 -> digit0 wraps to 0, digit1 becomes 4.
- DECADE_FAST_CARRY_EN build: 099 Inc -> 100 one cycle later, Ready constantly 1. 999 Inc -> 000 with the Overflow pulse on the same edge.

Source files
------------

// File: rtl/decade_counter_chain.sv
// rtl/decade_counter_chain.sv - multi-digit radix-(TOP+1) up/down counter with rippling carry/borrow
// Optional build macro DECADE_FAST_CARRY_EN resolves carry/borrow through all digits in one cycle.
module decade_counter_chain #(
  parameter int         DIGITS = 6,
  parameter logic [3:0] TOP    = 4'd9
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Inc,
  input  logic                Dec,
  input  logic                Clear,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadValue,
  output logic [4*DIGITS-1:0] Count,
  output logic                Ready,
  output logic                Zero,
  output logic                Overflow,
  output logic                Underflow
);

  typedef enum logic [1:0] {IDLE, CARRY_UP, BORROW_DN} state_t;

  state_t              state, state_n;
  logic [4*DIGITS-1:0] count_n;
  logic [2:0]          ptr, ptr_n;
  logic                ovf_n, unf_n;
`ifdef DECADE_FAST_CARRY_EN
  logic                carry;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      Count     <= '0;
      ptr       <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      state     <= state_n;
      Count     <= count_n;
      ptr       <= ptr_n;
      Overflow  <= ovf_n;
      Underflow <= unf_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = Count;
    ptr_n   = ptr;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
`ifdef DECADE_FAST_CARRY_EN
    carry   = 1'b0;
`endif
    if (Clear) begin
      count_n = '0;
      state_n = IDLE;
      ptr_n   = '0;
    end else if (Load) begin
      // Out-of-range digits are clamped so no digit ever exceeds TOP.
      for (int i = 0; i < DIGITS; i++)
        count_n[4*i +: 4] = (LoadValue[4*i +: 4] > TOP) ? TOP : LoadValue[4*i +: 4];
      state_n = IDLE;
      ptr_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (Inc && !Dec) begin
`ifdef DECADE_FAST_CARRY_EN
            carry = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
              if (carry) begin
                if (Count[4*i +: 4] < TOP) begin
                  count_n[4*i +: 4] = Count[4*i +: 4] + 4'd1;
                  carry = 1'b0;
                end else begin
                  count_n[4*i +: 4] = 4'd0;
                end
              end
            end
            ovf_n = carry;
`else
            if (Count[3:0] < TOP) begin
              count_n[3:0] = Count[3:0] + 4'd1;
            end else begin
              count_n[3:0] = 4'd0;
              if (DIGITS == 1) begin
                ovf_n = 1'b1;
              end else begin
                ptr_n   = 3'd1;
                state_n = CARRY_UP;
              end
            end
`endif
          end else if (Dec && !Inc) begin
`ifdef DECADE_FAST_CARRY_EN
            carry = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
              if (carry) begin
                if (Count[4*i +: 4] != 4'd0) begin
                  count_n[4*i +: 4] = Count[4*i +: 4] - 4'd1;
                  carry = 1'b0;
                end else begin
                  count_n[4*i +: 4] = TOP;
                end
              end
            end
            unf_n = carry;
`else
            if (Count[3:0] != 4'd0) begin
              count_n[3:0] = Count[3:0] - 4'd1;
            end else begin
              count_n[3:0] = TOP;
              if (DIGITS == 1) begin
                unf_n = 1'b1;
              end else begin
                ptr_n   = 3'd1;
                state_n = BORROW_DN;
              end
            end
`endif
          end
        end
        CARRY_UP: begin
          for (int i = 1; i < DIGITS; i++) begin
            if (3'(i) == ptr) begin
              if (Count[4*i +: 4] < TOP) begin
                count_n[4*i +: 4] = Count[4*i +: 4] + 4'd1;
                state_n = IDLE;
              end else begin
                count_n[4*i +: 4] = 4'd0;
                if (i == DIGITS - 1) begin
                  ovf_n   = 1'b1;
                  state_n = IDLE;
                end else begin
                  ptr_n = ptr + 3'd1;
                end
              end
            end
          end
        end
        BORROW_DN: begin
          for (int i = 1; i < DIGITS; i++) begin
            if (3'(i) == ptr) begin
              if (Count[4*i +: 4] != 4'd0) begin
                count_n[4*i +: 4] = Count[4*i +: 4] - 4'd1;
                state_n = IDLE;
              end else begin
                count_n[4*i +: 4] = TOP;
                if (i == DIGITS - 1) begin
                  unf_n   = 1'b1;
                  state_n = IDLE;
                end else begin
                  ptr_n = ptr + 3'd1;
                end
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign Ready = (state == IDLE);
  assign Zero  = (Count == '0);

endmodule

// File: tb/tb_decade_counter_chain.sv
// tb/tb_decade_counter_chain.sv - directed and randomized checks of decade_counter_chain against a value-level model
module tb_decade_counter_chain;
  localparam int D = 3;
  localparam int R = 10;

  logic        Clk = 1'b0;
  logic        Rst, Inc, Dec, Clear, Load;
  logic [11:0] LoadValue;
  logic [11:0] Count;
  logic        Ready, Zero, Overflow, Underflow;

  logic        b_Inc, b_Dec, b_Clear, b_Load;
  logic [11:0] b_LoadValue;
  logic [11:0] b_Count;
  logic        b_Ready, b_Zero, b_Overflow, b_Underflow;

  decade_counter_chain #(.DIGITS(D), .TOP(4'd9)) u_dut (
    .Clk(Clk), .Rst(Rst), .Inc(Inc), .Dec(Dec), .Clear(Clear), .Load(Load),
    .LoadValue(LoadValue), .Count(Count), .Ready(Ready), .Zero(Zero),
    .Overflow(Overflow), .Underflow(Underflow));

  decade_counter_chain #(.DIGITS(D), .TOP(4'd5)) u_hex (
    .Clk(Clk), .Rst(Rst), .Inc(b_Inc), .Dec(b_Dec), .Clear(b_Clear), .Load(b_Load),
    .LoadValue(b_LoadValue), .Count(b_Count), .Ready(b_Ready), .Zero(b_Zero),
    .Overflow(b_Overflow), .Underflow(b_Underflow));

  always #5 Clk = ~Clk;

  typedef struct {int val; bit rdy; bit ovf; bit unf;} snap_t;
  snap_t q[$];
  int    m_val;
  bit    m_rdy, m_ovf, m_unf;
  int    checks = 0;
  int    errors = 0;

  function automatic int pw(int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * R;
    return r;
  endfunction

  function automatic logic [11:0] enc(int v);
    logic [11:0] p;
    int          t = v;
    for (int i = 0; i < D; i++) begin
      p[4*i +: 4] = 4'(t % R);
      t = t / R;
    end
    return p;
  endfunction

  function automatic int from_load(logic [11:0] p);
    int v = 0;
    int d;
    for (int i = D - 1; i >= 0; i--) begin
      d = int'(p[4*i +: 4]);
      if (d > R - 1) d = R - 1;
      v = v * R + d;
    end
    return v;
  endfunction

  function automatic void apply_snap(snap_t s);
    m_val = s.val; m_rdy = s.rdy; m_ovf = s.ovf; m_unf = s.unf;
  endfunction

  // Expected state after one clock edge, computed on the whole counter value.
  function automatic void model_edge(bit inc, bit dec, bit clr, bit ld, logic [11:0] ldv);
    int    k;
    bit    wrap;
    int    fin;
    snap_t s;
    m_ovf = 1'b0; m_unf = 1'b0; m_rdy = 1'b1;
    if (clr) begin
      q.delete(); m_val = 0;
    end else if (ld) begin
      q.delete(); m_val = from_load(ldv);
    end else if (q.size() > 0) begin
      apply_snap(q.pop_front());
    end else if (inc != dec) begin
      k = 0;
      while (k < D && ((m_val / pw(k)) % R) == (inc ? R - 1 : 0)) k++;
      wrap = (k == D);
      if (wrap) k = D - 1;
      fin = inc ? (m_val + 1) % pw(D) : (m_val - 1 + pw(D)) % pw(D);
`ifndef DECADE_FAST_CARRY_EN
      for (int j = 0; j < k; j++) begin
        s.val = m_val - (m_val % pw(j + 1)) + (inc ? 0 : pw(j + 1) - 1);
        s.rdy = 1'b0; s.ovf = 1'b0; s.unf = 1'b0;
        q.push_back(s);
      end
`endif
      s.val = fin; s.rdy = 1'b1; s.ovf = wrap && inc; s.unf = wrap && dec;
      q.push_back(s);
      apply_snap(q.pop_front());
    end
  endfunction

  task automatic chk_all(string tag);
    checks++;
    assert (Count === enc(m_val)) else begin
      errors++; $error("FAIL %s Count got %h expected %h", tag, Count, enc(m_val));
    end
    checks++;
    assert (Ready === m_rdy) else begin
      errors++; $error("FAIL %s Ready got %b expected %b", tag, Ready, m_rdy);
    end
    checks++;
    assert (Overflow === m_ovf) else begin
      errors++; $error("FAIL %s Overflow got %b expected %b", tag, Overflow, m_ovf);
    end
    checks++;
    assert (Underflow === m_unf) else begin
      errors++; $error("FAIL %s Underflow got %b expected %b", tag, Underflow, m_unf);
    end
    checks++;
    assert (Zero === (m_val == 0)) else begin
      errors++; $error("FAIL %s Zero got %b expected %b", tag, Zero, (m_val == 0));
    end
  endtask

  task automatic cyc(bit inc, bit dec, bit clr, bit ld, logic [11:0] ldv, string tag);
    Inc = inc; Dec = dec; Clear = clr; Load = ld; LoadValue = ldv;
    @(posedge Clk);
    model_edge(inc, dec, clr, ld, ldv);
    #1;
    Inc = 1'b0; Dec = 1'b0; Clear = 1'b0; Load = 1'b0;
    chk_all(tag);
  endtask

  task automatic hex_chk(string tag, logic [11:0] exp_cnt, bit exp_rdy);
    checks++;
    assert (b_Count === exp_cnt && b_Ready === exp_rdy) else begin
      errors++;
      $error("FAIL %s Count/Ready got %h/%b expected %h/%b", tag, b_Count, b_Ready, exp_cnt, exp_rdy);
    end
  endtask

  initial begin
    logic [11:0] rv;
    int          r;
    Rst = 1'b1; Inc = 1'b0; Dec = 1'b0; Clear = 1'b0; Load = 1'b0; LoadValue = '0;
    b_Inc = 1'b0; b_Dec = 1'b0; b_Clear = 1'b0; b_Load = 1'b0; b_LoadValue = '0;
    m_val = 0; m_rdy = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    #12;
    chk_all("reset");
    Rst = 1'b0;

    cyc(0, 0, 0, 1, 12'h099, "ld099");
    cyc(1, 0, 0, 0, 12'h000, "rst_inc");
    #2 Rst = 1'b1;
    #1;
    q.delete(); m_val = 0; m_rdy = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    chk_all("async_rst");
    Rst = 1'b0;

    cyc(0, 0, 0, 1, 12'h099, "ld099b");
    cyc(1, 0, 0, 0, 12'h000, "rip1");
    cyc(1, 0, 0, 0, 12'h000, "rip2_ign");
    cyc(0, 0, 0, 0, 12'h000, "rip3");
    cyc(0, 0, 0, 0, 12'h000, "rip_hold");

    cyc(0, 0, 0, 1, 12'h999, "ld999");
    for (int i = 0; i < 4; i++) cyc(i == 0, 0, 0, 0, 12'h000, "ovf");
    cyc(0, 0, 1, 0, 12'h000, "clr");
    for (int i = 0; i < 4; i++) cyc(0, i == 0, 0, 0, 12'h000, "unf");

    cyc(0, 0, 0, 1, 12'h456, "ld456");
    cyc(1, 1, 0, 0, 12'h000, "incdec");
    cyc(0, 0, 1, 1, 12'h777, "clr_ld");
    cyc(0, 0, 0, 1, 12'h099, "ld099c");
    cyc(1, 0, 0, 0, 12'h000, "inc_then_ld");
    cyc(0, 0, 0, 1, 12'h777, "ld_abort");
    cyc(0, 0, 0, 0, 12'h000, "ld_abort_idle");
    cyc(0, 0, 0, 1, 12'hAF3, "clamp10");

    b_Load = 1'b1; b_LoadValue = 12'h735;
    @(posedge Clk); #1 b_Load = 1'b0;
    hex_chk("hex_clamp", 12'h535, 1'b1);
    b_Inc = 1'b1;
    @(posedge Clk); #1 b_Inc = 1'b0;
`ifdef DECADE_FAST_CARRY_EN
    hex_chk("hex_inc", 12'h540, 1'b1);
`else
    hex_chk("hex_inc1", 12'h530, 1'b0);
    @(posedge Clk); #1;
    hex_chk("hex_inc2", 12'h540, 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < D; i++) begin
        r = int'($urandom_range(0, 3));
        rv[4*i +: 4] = (r == 0) ? 4'd0 : (r == 1) ? 4'd9 : 4'($urandom_range(0, 15));
      end
      r = int'($urandom_range(0, 99));
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, r < 3, r >= 3 && r < 12, rv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
